// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if
// Purpose : bundles the fetch unit's instruction-memory, redirect and
//           decode-side signals so they travel as one port.
// Signals :
//   imem_req_valid  (fetch -> mem)  request valid
//   imem_req_ready  (mem -> fetch)  memory accepts request
//   imem_req_addr   (fetch -> mem)  word-aligned fetch address
//   imem_resp_valid (mem -> fetch)  in-order response valid
//   imem_resp_data  (mem -> fetch)  fetched instruction word
//   redirect        (exec -> fetch) taken branch/jump, flush and refetch
//   redirect_pc     (exec -> fetch) redirect target
//   inst_valid      (fetch -> dec)  instruction valid
//   inst_ready      (dec -> fetch)  decode accepts instruction
//   inst            (fetch -> dec)  instruction word
//   inst_pc         (fetch -> dec)  address of inst
// Modports: master = fetch unit side, slave = environment side.
// ---------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Purpose : single-outstanding instruction fetch stage. Issues one memory
//           request at a time, holds the returned word until decode takes
//           it, and flushes/refetches on a redirect from execute.
// Ports   :
//   clk      in  sole clock, rising edge
//   rst      in  synchronous active-high reset
//   io_fetch     fetch_unit_if.master (memory, redirect and decode signals)
// Parameter: RESET_PC - first fetch address after reset.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  io_fetch
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inflight_pc;
  logic        r_hold_valid;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic [31:0] w_inflight_pc_next;
  logic        w_hold_valid_next;
  logic [31:0] w_inst_next;
  logic [31:0] w_inst_pc_next;
  logic        w_req_valid;
  logic [31:0] w_redirect_target;

  // Low two target bits are dropped; fetch addresses are always word aligned.
  assign w_redirect_target = io_fetch.redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_inflight_pc_next = r_inflight_pc;
    w_hold_valid_next  = r_hold_valid;
    w_inst_next        = r_inst;
    w_inst_pc_next     = r_inst_pc;
    w_req_valid        = 1'b0;

    case (r_state)
      ST_ISSUE: begin
        w_req_valid = 1'b1;
        if (io_fetch.redirect) begin
          w_pc_next = w_redirect_target;
          // A request accepted this cycle carries the old address; its
          // response must be swallowed in DRAIN.
          w_state_next = io_fetch.imem_req_ready ? ST_DRAIN : ST_ISSUE;
        end else if (io_fetch.imem_req_ready) begin
          w_inflight_pc_next = r_pc;
          w_state_next       = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (io_fetch.redirect) begin
          w_pc_next    = w_redirect_target;
          // A response arriving with the redirect is simply dropped, so
          // nothing remains outstanding and fetch can restart at once.
          w_state_next = io_fetch.imem_resp_valid ? ST_ISSUE : ST_DRAIN;
        end else if (io_fetch.imem_resp_valid) begin
          w_inst_next       = io_fetch.imem_resp_data;
          w_inst_pc_next    = r_inflight_pc;
          w_hold_valid_next = 1'b1;
          w_state_next      = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (io_fetch.redirect) begin
          w_pc_next         = w_redirect_target;
          w_hold_valid_next = 1'b0;
          w_state_next      = ST_ISSUE;
        end else if (io_fetch.inst_ready) begin
          // 32-bit add wraps naturally past 32'hFFFF_FFFC.
          w_pc_next         = r_inst_pc + 32'd4;
          w_hold_valid_next = 1'b0;
          w_state_next      = ST_ISSUE;
        end
      end

      ST_DRAIN: begin
        if (io_fetch.redirect) begin
          w_pc_next = w_redirect_target;
          // Stay until the stale response is seen; if it shows up in this
          // very cycle it is consumed here, otherwise we would wait forever.
          if (io_fetch.imem_resp_valid) begin
            w_state_next = ST_ISSUE;
          end
        end else if (io_fetch.imem_resp_valid) begin
          w_state_next = ST_ISSUE;
        end
      end

      default: begin
        w_state_next = ST_ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_ISSUE;
      r_pc          <= RESET_PC;
      r_inflight_pc <= 32'd0;
      r_hold_valid  <= 1'b0;
      r_inst        <= 32'd0;
      r_inst_pc     <= 32'd0;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_inflight_pc <= w_inflight_pc_next;
      r_hold_valid  <= w_hold_valid_next;
      r_inst        <= w_inst_next;
      r_inst_pc     <= w_inst_pc_next;
    end
  end

  assign io_fetch.imem_req_valid = w_req_valid;
  assign io_fetch.imem_req_addr  = r_pc;
  // Redirect squashes the held instruction combinationally so decode can
  // never take a wrong-path word in the redirect cycle.
  assign io_fetch.inst_valid     = r_hold_valid & ~io_fetch.redirect;
  assign io_fetch.inst           = r_inst;
  assign io_fetch.inst_pc        = r_inst_pc;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port imem_req_valid  output  1  fetch request valid.
REQ-005 SHALL provide port imem_req_ready  input  1  instruction memory accepts request.
REQ-006 SHALL provide port imem_req_addr  output  32  fetch address, word aligned.
REQ-007 SHALL provide port imem_resp_valid  input  1  response data valid; in order, variable latency of 1 or more cycles.
REQ-008 SHALL provide port imem_resp_data  input  32  fetched instruction word.
REQ-009 SHALL provide port redirect  input  1  taken branch/jump from execute; flush and refetch.
REQ-010 SHALL provide port redirect_pc  input  32  redirect target.
REQ-011 SHALL provide port inst_valid  output  1  instruction to decode valid.
REQ-012 SHALL provide port inst_ready  input  1  decode accepts instruction.
REQ-013 SHALL provide port inst  output  32  instruction word.
REQ-014 SHALL provide port inst_pc  output  32  address of inst.

Function
REQ-015 SHALL implement states ISSUE, WAIT, HOLD and DRAIN, with at most one memory request outstanding.
REQ-016 In ISSUE, SHALL drive imem_req_valid=1 and imem_req_addr=pc; on imem_req_ready, SHALL latch pc as inflight_pc and go to WAIT.
REQ-017 In WAIT, SHALL hold imem_req_valid=0; on imem_resp_valid, SHALL capture imem_resp_data into inst and inflight_pc into inst_pc, and go to HOLD, giving inst_valid=1 exactly 1 cycle after the response.
REQ-018 In HOLD, SHALL keep inst and inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-019 On a HOLD handshake (inst_valid and inst_ready), SHALL update pc to inst_pc+4 and go to ISSUE.
REQ-020 Every pc increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 -> 0).
REQ-021 redirect SHALL take priority over all other events in every state.
REQ-022 On redirect, SHALL load pc with {redirect_pc[31:2],2'b00}, ignoring bits [1:0].
REQ-023 inst_valid SHALL equal hold_valid AND NOT redirect, a combinational squash; no handshake SHALL complete in a redirect cycle.
REQ-024 On redirect in HOLD, SHALL discard the held instruction and go to ISSUE.
REQ-025 On redirect in WAIT without imem_resp_valid, SHALL go to DRAIN; with imem_resp_valid in the same cycle, SHALL discard the response and go to ISSUE.
REQ-026 On redirect in ISSUE with imem_req_ready, the old-address request is accepted and SHALL be discarded by going to DRAIN; without imem_req_ready, SHALL stay in ISSUE with the new pc.
REQ-027 imem_req_addr MAY change while imem_req_valid=1 and imem_req_ready=0; only the handshake-cycle address is binding.
REQ-028 In DRAIN, SHALL hold imem_req_valid=0 and inst_valid=0; the next imem_resp_valid SHALL be dropped and the state SHALL go to ISSUE.
REQ-029 On redirect during DRAIN, SHALL update pc and remain in DRAIN.
REQ-030 imem_resp_valid in ISSUE or HOLD SHALL be ignored; it is a protocol error and SHALL NOT change state.

Reset
REQ-031 While rst=1, SHALL set state=ISSUE, pc=RESET_PC, hold_valid=0, inst=0 and inst_pc=0; imem_req_valid SHALL go 1 in the first cycle after rst deasserts.
REQ-032 rst SHALL override redirect and all handshakes in the same cycle.
REQ-033 rst mid-operation SHALL abandon any outstanding request; memory is reset by the same rst.

Verification
REQ-034 Bench SHALL cover: reset release, RESET_PC=0x100, memory always ready, 2-cycle latency -> inst_pc sequence 0x100, 0x104, 0x108, with inst_valid 1 cycle after each response.
REQ-035 Bench SHALL cover: inst_ready=0 for 5 cycles in HOLD -> inst and inst_pc stable, no new imem request issued.
REQ-036 Bench SHALL cover: redirect to 0x203 in WAIT -> DRAIN, stale response dropped, next request address 0x200, first delivered inst_pc 0x200.
REQ-037 Bench SHALL cover: redirect in the same cycle as imem_resp_valid in WAIT -> response dropped, request to the new pc issued the next cycle, no DRAIN.
REQ-038 Bench SHALL cover: redirect in HOLD with inst_ready=1 -> inst_valid=0 that cycle, no transfer, next request at redirect target.
REQ-039 Bench SHALL cover: pc=0xFFFF_FFFC consumed -> next request address 0x0000_0000; rst asserted in WAIT -> next request at RESET_PC.
